// File: rtl/eth_fifo_ctrl.sv
// Frame-aware byte FIFO sequencer for an external registered-read dual-port RAM.
// Good frames commit on tlast, bad or oversize frames are rewound or dropped.
module eth_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_s_tdata,
    input  logic                  i_s_tvalid,
    input  logic                  i_s_tlast,
    input  logic                  i_s_tuser,
    output logic                  o_s_tready,
    output logic                  o_mem_wr_en,
    output logic [ADDR_BITS-1:0]  o_mem_wr_addr,
    output logic [DATA_WIDTH:0]   o_mem_wr_data,
    output logic                  o_mem_rd_en,
    output logic [ADDR_BITS-1:0]  o_mem_rd_addr,
    input  logic [DATA_WIDTH:0]   i_mem_rd_data,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tvalid,
    output logic                  o_m_tlast,
    input  logic                  i_m_tready,
    output logic [15:0]           o_drop_cnt,
    output logic [ADDR_BITS:0]    o_level
);

    localparam int PW = ADDR_BITS + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(MEM_DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP
    } state_t;

    state_t              state;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       commit_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                run;
    logic [15:0]         drop_cnt;
    logic [DATA_WIDTH:0] buf_q [2];
    logic                head;
    logic [1:0]          cnt;
    logic                in_flight;

    logic                full;
    logic                avail;
    logic                oversize;
    logic                s_fire;
    logic                wr_fire;
    logic                drop_evt;
    logic                pop;
    logic                rd_fire;
    logic [2:0]          occ_next;

    always_comb begin
        full       = (wr_ptr - rd_ptr) == DEPTH_P;
        avail      = commit_ptr != rd_ptr;
        oversize   = (wr_ptr - commit_ptr) == DEPTH_P;
        o_s_tready = run & ((state == DROP) | ~full);
        s_fire     = i_s_tvalid & o_s_tready;
        wr_fire    = s_fire & (state != DROP);
        drop_evt   = s_fire & i_s_tlast & ((state == DROP) | i_s_tuser);
        pop        = o_m_tvalid & i_m_tready;
        // Entries buffered or arriving, after this cycle's pop.
        occ_next   = {1'b0, cnt} + {2'b00, in_flight} - {2'b00, pop};
        rd_fire    = avail & (occ_next < 3'd2);
    end

    assign o_mem_wr_en   = wr_fire;
    assign o_mem_wr_addr = wr_ptr[ADDR_BITS-1:0];
    assign o_mem_wr_data = {i_s_tlast, i_s_tdata};
    assign o_mem_rd_en   = rd_fire;
    assign o_mem_rd_addr = rd_ptr[ADDR_BITS-1:0];
    assign o_m_tvalid    = cnt != 2'd0;
    assign o_m_tdata     = buf_q[head][DATA_WIDTH-1:0];
    assign o_m_tlast     = buf_q[head][DATA_WIDTH];
    assign o_drop_cnt    = drop_cnt;
    assign o_level       = wr_ptr - rd_ptr;

    // Holds tready low while in reset and until the first clock after it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            case (state)
                IDLE, FRAME: begin
                    if (wr_fire) begin
                        if (i_s_tlast) begin
                            state <= IDLE;
                            if (i_s_tuser) begin
                                wr_ptr <= commit_ptr;
                            end else begin
                                wr_ptr     <= wr_ptr + ONE_P;
                                commit_ptr <= wr_ptr + ONE_P;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + ONE_P;
                            state  <= FRAME;
                        end
                    end else if (oversize) begin
                        // Frame fills the whole memory: give it up.
                        wr_ptr <= commit_ptr;
                        state  <= DROP;
                    end
                end
                DROP: begin
                    if (s_fire & i_s_tlast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= rd_fire;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
        end
    end

    // Two-entry prefetch ring; the tail slot is head + cnt.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head     <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (in_flight) begin
                buf_q[head ^ cnt[0]] <= i_mem_rd_data;
            end
            if (pop) begin
                head <= ~head;
            end
            cnt <= cnt + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_eth_fifo_ctrl.sv
// Bench for eth_fifo_ctrl: RAM model, frame-level scoreboard and directed phases.
// Expected bytes come from frame rules (commit good, drop bad or > depth).
module tb_eth_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AB    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          s_tready;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DW:0]   wr_data;
    logic          rd_en;
    logic [AB-1:0] rd_addr;
    logic [DW:0]   rd_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [15:0]   drop_cnt;
    logic [AB:0]   level;

    eth_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_s_tdata(s_tdata),
        .i_s_tvalid(s_tvalid),
        .i_s_tlast(s_tlast),
        .i_s_tuser(s_tuser),
        .o_s_tready(s_tready),
        .o_mem_wr_en(wr_en),
        .o_mem_wr_addr(wr_addr),
        .o_mem_wr_data(wr_data),
        .o_mem_rd_en(rd_en),
        .o_mem_rd_addr(rd_addr),
        .i_mem_rd_data(rd_data),
        .o_m_tdata(m_tdata),
        .o_m_tvalid(m_tvalid),
        .o_m_tlast(m_tlast),
        .i_m_tready(m_tready),
        .o_drop_cnt(drop_cnt),
        .o_level(level)
    );

    always #5 clk = ~clk;

    logic [DW:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame-level model state.
    logic [DW:0] exp_q[$];
    logic [DW:0] pend[$];
    int          flen = 0;
    int          commit_cnt = 0;
    logic [15:0] m_drop = '0;
    int          n_pop = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_out = '0;
    logic        rand_rdy = 1'b0;

    task automatic bump_drop();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l,
                                input logic u);
        if (flen >= DEPTH) begin
            if (l) begin
                bump_drop();
                flen = 0;
                pend.delete();
            end
        end else begin
            pend.push_back({l, d});
            flen++;
            if (l) begin
                if (u) begin
                    bump_drop();
                end else begin
                    foreach (pend[i]) exp_q.push_back(pend[i]);
                    commit_cnt += flen;
                end
                flen = 0;
                pend.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        logic        exp_we;
        logic [DW:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            exp_we = s_tvalid & s_tready & (flen < DEPTH);
            chk("wr_en", 32'(wr_en), 32'(exp_we));
            if (exp_we)
                chk("wr_addr", 32'(wr_addr), 32'((commit_cnt + flen) % DEPTH));
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'({m_tlast, m_tdata}), 32'(prev_out));
            end
            if (m_tvalid & m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL spurious_out actual=%0h required=none",
                             {m_tlast, m_tdata});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 32'({m_tlast, m_tdata}), 32'(e));
                end
                n_pop++;
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_out = {m_tlast, m_tdata};
            if (s_tvalid & s_tready) model_accept(s_tdata, s_tlast, s_tuser);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int n, input int base, input int step,
                        input logic last, input logic bad);
        logic acc;
        int   w;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata = 8'(base + i * step);
            s_tlast = last && (i == n - 1);
            s_tuser = bad && (i == n - 1);
            w = 0;
            do begin
                @(negedge clk);
                acc = s_tready;
                tick();
                w++;
            end while (!acc && w < 5000);
            if (!acc) begin
                checks++;
                fails++;
                $display("FAIL send_timeout actual=stalled required=accept");
                i = n;
            end
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || m_tvalid) && w < 5000) begin
            tick();
            w++;
        end
        if (w >= 5000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        exp_q.delete();
        pend.delete();
        flen = 0;
        commit_cnt = 0;
        m_drop = '0;
        tick();
        tick();
        s_tvalid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    logic tx_done;

    initial begin
        int e0, p0, w, nbad, len;
        logic bad;
        tick();
        s_tvalid = 1'b1;
        do_reset();
        chk("idle_tready", 32'(s_tready), 32'd1);

        // Good 4-byte frame, sink always ready.
        m_tready = 1'b1;
        send(4, 8'h11, 8'h11, 1'b1, 1'b0);
        e0 = edge_cnt;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!m_tvalid && w < 20);
        chk("latency", 32'(edge_cnt - e0), 32'd2);
        chk("b0", 32'({m_tvalid, m_tlast, m_tdata}), 32'h211);
        @(negedge clk);
        chk("b1", 32'({m_tvalid, m_tlast, m_tdata}), 32'h222);
        @(negedge clk);
        chk("b2", 32'({m_tvalid, m_tlast, m_tdata}), 32'h233);
        @(negedge clk);
        chk("b3", 32'({m_tvalid, m_tlast, m_tdata}), 32'h344);
        drain();
        chk("lvl_after_1", 32'(level), 32'd0);

        // Bad 5-byte frame, then good 3-byte frame.
        p0 = n_pop;
        send(5, 8'hA0, 1, 1'b1, 1'b1);
        send(3, 8'hB0, 1, 1'b1, 1'b0);
        drain();
        chk("drop_1", 32'(drop_cnt), 32'd1);
        chk("wptr_after_bad", 32'(wr_addr), 32'd7);
        chk("pops_bad_good", 32'(n_pop - p0), 32'd3);
        chk("lvl_after_2", 32'(level), 32'd0);

        // Two 40-byte frames into a stalled sink.
        m_tready = 1'b0;
        p0 = n_pop;
        send(40, 8'h00, 1, 1'b1, 1'b0);
        tx_done = 1'b0;
        fork
            begin
                send(40, 8'h40, 1, 1'b1, 1'b0);
                tx_done = 1'b1;
            end
        join_none
        w = 0;
        while (s_tready && w < 500) begin
            tick();
            w++;
        end
        tick();
        tick();
        chk("full_tready", 32'(s_tready), 32'd0);
        chk("full_level", 32'(level), 32'd64);
        m_tready = 1'b1;
        w = 0;
        while (!tx_done && w < 2000) begin
            tick();
            w++;
        end
        chk("second_sent", 32'(tx_done), 32'd1);
        drain();
        chk("pops_80", 32'(n_pop - p0), 32'd80);

        // 70-byte frame overflows an empty FIFO and is dropped.
        p0 = n_pop;
        send(70, 8'hC0, 1, 1'b1, 1'b0);
        repeat (6) tick();
        chk("drop_2", 32'(drop_cnt), 32'd2);
        chk("pops_oversize", 32'(n_pop - p0), 32'd0);
        chk("wptr_oversize", 32'(wr_addr), 32'd23);
        chk("lvl_oversize", 32'(level), 32'd0);
        chk("tready_oversize", 32'(s_tready), 32'd1);

        // Random frames with a randomly stalling sink.
        nbad = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 12);
            bad = ($urandom_range(0, 3) == 0);
            if (bad) nbad++;
            send(len, $urandom_range(0, 255), $urandom_range(1, 255), 1'b1, bad);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        drain();
        chk("drop_random", 32'(drop_cnt), 32'(2 + nbad));
        chk("lvl_random", 32'(level), 32'd0);

        // Reset in the middle of a frame.
        send(5, 8'h50, 1, 1'b0, 1'b0);
        s_tvalid = 1'b1;
        do_reset();
        p0 = n_pop;
        send(6, 8'h60, 1, 1'b1, 1'b0);
        drain();
        chk("pops_post_rst1", 32'(n_pop - p0), 32'd6);
        chk("drop_post_rst1", 32'(drop_cnt), 32'd0);

        // Reset in the middle of a drain.
        m_tready = 1'b0;
        send(20, 8'hD0, 1, 1'b1, 1'b0);
        repeat (3) tick();
        m_tready = 1'b1;
        repeat (4) tick();
        chk("mid_drain_valid", 32'(m_tvalid), 32'd1);
        do_reset();
        p0 = n_pop;
        send(3, 8'hE0, 1, 1'b1, 1'b0);
        drain();
        chk("pops_post_rst2", 32'(n_pop - p0), 32'd3);
        chk("lvl_post_rst2", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
